// File: rtl/lifo_stack_param_if.sv
// Push/pop request and status bundle for the parametrised LIFO.
// Master drives requests and data, slave returns popped data and flags.
interface lifo_stack_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) ();
  logic                  iClear;
  logic                  iPush;
  logic                  iPop;
  logic [DATA_WIDTH-1:0] iData;
  logic [DATA_WIDTH-1:0] oData;
  logic                  oValid;
  logic [ADDR_WIDTH:0]   oCount;
  logic                  oFull;
  logic                  oEmpty;
  logic                  oAlmostFull;
  logic                  oAlmostEmpty;
  logic                  oOverflow;
  logic                  oUnderflow;

  modport master (
    output iClear, iPush, iPop, iData,
    input  oData, oValid, oCount, oFull, oEmpty,
    input  oAlmostFull, oAlmostEmpty, oOverflow, oUnderflow
  );

  modport slave (
    input  iClear, iPush, iPop, iData,
    output oData, oValid, oCount, oFull, oEmpty,
    output oAlmostFull, oAlmostEmpty, oOverflow, oUnderflow
  );
endinterface

// File: rtl/lifo_stack_param.sv
// Parametrised LIFO with registered pop port, occupancy flags,
// sticky overflow/underflow and defined push+pop replace/bypass.
module lifo_stack_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1
) (
  input logic              iClk,
  input logic              iRst_n,
  lifo_stack_param_if.slave bus
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] AfThr  = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AeThr  = CW'(AE_MARGIN);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] dataQ;
  logic                  validQ;
  logic                  ovfQ;
  logic                  unfQ;

  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH-1:0] topIdx;
  logic [ADDR_WIDTH-1:0] wrIdx;
  logic                  live;
  logic                  both;
  logic                  pushOnly;
  logic                  popOnly;

  assign full     = (count == DepthC);
  assign empty    = (count == '0);
  assign topIdx   = ADDR_WIDTH'(count - 1'b1);
  assign wrIdx    = ADDR_WIDTH'(count);
  assign live     = !bus.iClear;
  assign both     = live && bus.iPush && bus.iPop;
  assign pushOnly = live && bus.iPush && !bus.iPop;
  assign popOnly  = live && !bus.iPush && bus.iPop;

  // Storage is not reset; only count decides what is meaningful.
  always_ff @(posedge iClk) begin
    if (pushOnly && !full)
      mem[wrIdx] <= bus.iData;
    else if (both && !empty)
      mem[topIdx] <= bus.iData;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      count  <= '0;
      dataQ  <= '0;
      validQ <= 1'b0;
      ovfQ   <= 1'b0;
      unfQ   <= 1'b0;
    end else begin
      validQ <= 1'b0;
      unique case (1'b1)
        bus.iClear: begin
          count <= '0;
          ovfQ  <= 1'b0;
          unfQ  <= 1'b0;
        end
        both && !empty: begin
          dataQ  <= mem[topIdx];
          validQ <= 1'b1;
        end
        both && empty: begin
          dataQ  <= bus.iData;
          validQ <= 1'b1;
        end
        pushOnly && !full: count <= count + 1'b1;
        pushOnly && full:  ovfQ  <= 1'b1;
        popOnly && !empty: begin
          dataQ  <= mem[topIdx];
          validQ <= 1'b1;
          count  <= count - 1'b1;
        end
        popOnly && empty: unfQ <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.oData        = dataQ;
  assign bus.oValid       = validQ;
  assign bus.oCount       = count;
  assign bus.oFull        = full;
  assign bus.oEmpty       = empty;
  assign bus.oAlmostFull  = (count >= AfThr);
  assign bus.oAlmostEmpty = (count <= AeThr);
  assign bus.oOverflow    = ovfQ;
  assign bus.oUnderflow   = unfQ;

endmodule

// File: tb/tb_lifo_stack_param.sv
// Directed bench for lifo_stack_param: default 8x32 instance
// plus a 1-bit, 20-deep instance for non-power-of-two depth.
module tb_lifo_stack_param;

  logic iClk;
  logic iRst_n;
  logic iRst2_n;
  int   checks;
  int   failures;

  lifo_stack_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bus ();
  lifo_stack_param_if #(.DATA_WIDTH(1), .ADDR_WIDTH(5)) bus2 ();

  lifo_stack_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(32),
    .AF_MARGIN(1), .AE_MARGIN(1)
  ) dut (
    .iClk(iClk), .iRst_n(iRst_n), .bus(bus)
  );

  lifo_stack_param #(
    .DATA_WIDTH(1), .ADDR_WIDTH(5), .DEPTH(20),
    .AF_MARGIN(1), .AE_MARGIN(1)
  ) dut2 (
    .iClk(iClk), .iRst_n(iRst2_n), .bus(bus2)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic step(input logic pu, input logic po,
                      input logic [7:0] d);
    bus.iPush = pu;
    bus.iPop  = po;
    bus.iData = d;
    @(posedge iClk);
    #1;
    bus.iPush = 1'b0;
    bus.iPop  = 1'b0;
  endtask

  task automatic step2(input logic pu, input logic po,
                       input logic d);
    bus2.iPush = pu;
    bus2.iPop  = po;
    bus2.iData = d;
    @(posedge iClk);
    #1;
    bus2.iPush = 1'b0;
    bus2.iPop  = 1'b0;
  endtask

  task automatic doClear();
    bus.iClear = 1'b1;
    @(posedge iClk);
    #1;
    bus.iClear = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.oCount !== 6'd0 || bus.oEmpty !== 1'b1 ||
        bus.oFull !== 1'b0 || bus.oAlmostEmpty !== 1'b1 ||
        bus.oAlmostFull !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: count=%0d e=%b f=%b ae=%b af=%b want 0 1 0 1 0",
               bus.oCount, bus.oEmpty, bus.oFull,
               bus.oAlmostEmpty, bus.oAlmostFull);
    end
    checks++;
    if (bus.oValid !== 1'b0 || bus.oData !== 8'h00 ||
        bus.oOverflow !== 1'b0 || bus.oUnderflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs: v=%b d=%h ovf=%b unf=%b want 0 00 0 0",
               bus.oValid, bus.oData, bus.oOverflow, bus.oUnderflow);
    end
  endtask

  task automatic test_order();
    logic [7:0] exp [3];
    exp[0] = 8'hC3;
    exp[1] = 8'hB2;
    exp[2] = 8'hA1;
    step(1, 0, 8'hA1);
    step(1, 0, 8'hB2);
    step(1, 0, 8'hC3);
    checks++;
    if (bus.oCount !== 6'd3 || bus.oAlmostEmpty !== 1'b0) begin
      failures++;
      $display("FAIL order_count: count=%0d ae=%b want 3 0",
               bus.oCount, bus.oAlmostEmpty);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 8'h00);
      checks++;
      if (bus.oValid !== 1'b1 || bus.oData !== exp[i] ||
          bus.oCount !== 6'(2 - i)) begin
        failures++;
        $display("FAIL order_pop%0d: v=%b d=%h count=%0d want 1 %h %0d",
                 i, bus.oValid, bus.oData, bus.oCount, exp[i], 2 - i);
      end
    end
    checks++;
    if (bus.oEmpty !== 1'b1) begin
      failures++;
      $display("FAIL order_empty: empty=%b want 1", bus.oEmpty);
    end
  endtask

  task automatic test_fill();
    logic [7:0] w;
    for (int i = 0; i < 32; i++) begin
      w = 8'(i * 7 + 3);
      step(1, 0, w);
      if (i == 29) begin
        checks++;
        if (bus.oAlmostFull !== 1'b0) begin
          failures++;
          $display("FAIL fill_af30: af=%b want 0", bus.oAlmostFull);
        end
      end
      if (i == 30) begin
        checks++;
        if (bus.oAlmostFull !== 1'b1 || bus.oFull !== 1'b0) begin
          failures++;
          $display("FAIL fill_af31: af=%b full=%b want 1 0",
                   bus.oAlmostFull, bus.oFull);
        end
      end
    end
    checks++;
    if (bus.oFull !== 1'b1 || bus.oCount !== 6'd32 ||
        bus.oOverflow !== 1'b0) begin
      failures++;
      $display("FAIL fill_full: full=%b count=%0d ovf=%b want 1 32 0",
               bus.oFull, bus.oCount, bus.oOverflow);
    end
    step(1, 0, 8'hEE);
    checks++;
    if (bus.oOverflow !== 1'b1 || bus.oCount !== 6'd32) begin
      failures++;
      $display("FAIL fill_ovf: ovf=%b count=%0d want 1 32",
               bus.oOverflow, bus.oCount);
    end
    for (int i = 31; i >= 0; i--) begin
      w = 8'(i * 7 + 3);
      step(0, 1, 8'h00);
      checks++;
      if (bus.oValid !== 1'b1 || bus.oData !== w) begin
        failures++;
        $display("FAIL fill_pop%0d: v=%b d=%h want 1 %h",
                 i, bus.oValid, bus.oData, w);
      end
    end
    checks++;
    if (bus.oOverflow !== 1'b1 || bus.oEmpty !== 1'b1) begin
      failures++;
      $display("FAIL fill_sticky: ovf=%b empty=%b want 1 1",
               bus.oOverflow, bus.oEmpty);
    end
  endtask

  task automatic test_underflow_clear();
    step(0, 1, 8'h00);
    checks++;
    if (bus.oUnderflow !== 1'b1 || bus.oValid !== 1'b0 ||
        bus.oData !== 8'h03 || bus.oCount !== 6'd0) begin
      failures++;
      $display("FAIL underflow: unf=%b v=%b d=%h count=%0d want 1 0 03 0",
               bus.oUnderflow, bus.oValid, bus.oData, bus.oCount);
    end
    step(0, 0, 8'h00);
    checks++;
    if (bus.oUnderflow !== 1'b1) begin
      failures++;
      $display("FAIL underflow_sticky: unf=%b want 1", bus.oUnderflow);
    end
    doClear();
    checks++;
    if (bus.oUnderflow !== 1'b0 || bus.oOverflow !== 1'b0) begin
      failures++;
      $display("FAIL clear_errs: unf=%b ovf=%b want 0 0",
               bus.oUnderflow, bus.oOverflow);
    end
  endtask

  task automatic test_clear_priority();
    step(1, 0, 8'h44);
    step(1, 0, 8'h55);
    bus.iClear = 1'b1;
    bus.iPush  = 1'b1;
    bus.iPop   = 1'b1;
    bus.iData  = 8'h66;
    @(posedge iClk);
    #1;
    bus.iClear = 1'b0;
    bus.iPush  = 1'b0;
    bus.iPop   = 1'b0;
    checks++;
    if (bus.oCount !== 6'd0 || bus.oValid !== 1'b0 ||
        bus.oData !== 8'h03) begin
      failures++;
      $display("FAIL clear_prio: count=%0d v=%b d=%h want 0 0 03",
               bus.oCount, bus.oValid, bus.oData);
    end
  endtask

  task automatic test_push_pop_replace();
    step(1, 0, 8'h11);
    step(1, 0, 8'h22);
    step(1, 1, 8'h33);
    checks++;
    if (bus.oData !== 8'h22 || bus.oValid !== 1'b1 ||
        bus.oCount !== 6'd2 || bus.oOverflow !== 1'b0 ||
        bus.oUnderflow !== 1'b0) begin
      failures++;
      $display("FAIL replace: d=%h v=%b count=%0d want 22 1 2",
               bus.oData, bus.oValid, bus.oCount);
    end
    step(0, 1, 8'h00);
    checks++;
    if (bus.oData !== 8'h33 || bus.oValid !== 1'b1) begin
      failures++;
      $display("FAIL replace_pop1: d=%h v=%b want 33 1",
               bus.oData, bus.oValid);
    end
    step(0, 1, 8'h00);
    checks++;
    if (bus.oData !== 8'h11 || bus.oCount !== 6'd0) begin
      failures++;
      $display("FAIL replace_pop2: d=%h count=%0d want 11 0",
               bus.oData, bus.oCount);
    end
  endtask

  task automatic test_bypass();
    step(1, 1, 8'h5A);
    checks++;
    if (bus.oData !== 8'h5A || bus.oValid !== 1'b1 ||
        bus.oCount !== 6'd0 || bus.oOverflow !== 1'b0 ||
        bus.oUnderflow !== 1'b0) begin
      failures++;
      $display("FAIL bypass: d=%h v=%b count=%0d ovf=%b unf=%b want 5a 1 0 0 0",
               bus.oData, bus.oValid, bus.oCount,
               bus.oOverflow, bus.oUnderflow);
    end
    step(0, 0, 8'h00);
    checks++;
    if (bus.oValid !== 1'b0 || bus.oData !== 8'h5A) begin
      failures++;
      $display("FAIL idle_hold: v=%b d=%h want 0 5a",
               bus.oValid, bus.oData);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 8'(8'h80 + i));
    step(0, 1, 8'h00);
    checks++;
    if (bus.oValid !== 1'b1 || bus.oData !== 8'h89 ||
        bus.oCount !== 6'd9) begin
      failures++;
      $display("FAIL burst_pop: v=%b d=%h count=%0d want 1 89 9",
               bus.oValid, bus.oData, bus.oCount);
    end
    bus.iPush = 1'b1;
    bus.iData = 8'hAA;
    #2;
    iRst_n = 1'b0;
    #1;
    checks++;
    if (bus.oCount !== 6'd0 || bus.oValid !== 1'b0 ||
        bus.oData !== 8'h00) begin
      failures++;
      $display("FAIL async_rst: count=%0d v=%b d=%h want 0 0 00",
               bus.oCount, bus.oValid, bus.oData);
    end
    @(posedge iClk);
    #3;
    bus.iPush = 1'b0;
    iRst_n = 1'b1;
    step(1, 0, 8'h7E);
    checks++;
    if (bus.oCount !== 6'd1) begin
      failures++;
      $display("FAIL rst_push: count=%0d want 1", bus.oCount);
    end
    step(0, 1, 8'h00);
    checks++;
    if (bus.oData !== 8'h7E || bus.oValid !== 1'b1 ||
        bus.oEmpty !== 1'b1) begin
      failures++;
      $display("FAIL rst_pop: d=%h v=%b empty=%b want 7e 1 1",
               bus.oData, bus.oValid, bus.oEmpty);
    end
  endtask

  task automatic test_depth20();
    logic b;
    step2(1, 0, 1'b1);
    step2(1, 0, 1'b0);
    step2(1, 0, 1'b1);
    bus2.iPush = 1'b1;
    bus2.iData = 1'b0;
    #2;
    iRst2_n = 1'b0;
    #1;
    checks++;
    if (bus2.oCount !== 6'd0 || bus2.oValid !== 1'b0) begin
      failures++;
      $display("FAIL d20_rst: count=%0d v=%b want 0 0",
               bus2.oCount, bus2.oValid);
    end
    @(posedge iClk);
    #3;
    bus2.iPush = 1'b0;
    iRst2_n = 1'b1;
    step2(1, 0, 1'b1);
    step2(0, 1, 1'b0);
    checks++;
    if (bus2.oData !== 1'b1 || bus2.oValid !== 1'b1 ||
        bus2.oCount !== 6'd0) begin
      failures++;
      $display("FAIL d20_7e: d=%b v=%b count=%0d want 1 1 0",
               bus2.oData, bus2.oValid, bus2.oCount);
    end
    for (int i = 0; i < 20; i++) begin
      b = ((i % 3) == 0);
      step2(1, 0, b);
      if (i == 18) begin
        checks++;
        if (bus2.oAlmostFull !== 1'b1 || bus2.oFull !== 1'b0) begin
          failures++;
          $display("FAIL d20_af19: af=%b full=%b want 1 0",
                   bus2.oAlmostFull, bus2.oFull);
        end
      end
    end
    step2(1, 0, 1'b0);
    checks++;
    if (bus2.oFull !== 1'b1 || bus2.oCount !== 6'd20 ||
        bus2.oOverflow !== 1'b1) begin
      failures++;
      $display("FAIL d20_full: full=%b count=%0d ovf=%b want 1 20 1",
               bus2.oFull, bus2.oCount, bus2.oOverflow);
    end
    for (int i = 19; i >= 0; i--) begin
      b = ((i % 3) == 0);
      step2(0, 1, 1'b0);
      checks++;
      if (bus2.oData !== b || bus2.oValid !== 1'b1) begin
        failures++;
        $display("FAIL d20_pop%0d: d=%b v=%b want %b 1",
                 i, bus2.oData, bus2.oValid, b);
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    iRst_n     = 1'b0;
    iRst2_n    = 1'b0;
    bus.iClear = 1'b0;
    bus.iPush  = 1'b0;
    bus.iPop   = 1'b0;
    bus.iData  = 8'h00;
    bus2.iClear = 1'b0;
    bus2.iPush  = 1'b0;
    bus2.iPop   = 1'b0;
    bus2.iData  = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    test_reset();
    iRst_n  = 1'b1;
    iRst2_n = 1'b1;
    test_order();
    test_fill();
    test_underflow_clear();
    test_clear_priority();
    test_push_pop_replace();
    test_bypass();
    test_async_reset();
    test_depth20();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
